spike_event_encoder: RTL and testbench

SPIKE_EVENT_ENCODER -- requirements
Module: spike_event_encoder

---
 rtl/spike_event_encoder_if.sv | 37 +++
 rtl/spike_event_encoder.sv | 92 +++++++++
 tb/tb_spike_event_encoder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_event_encoder_if.sv
// Spike vector in / address-event out handshake bundle.
// slave = encoder side, master = producer of spikes and event sink.
interface spike_event_encoder_if #(
  parameter int N  = 8,
  parameter int AW = 3
) ();
  logic [N-1:0]  spikes;
  logic          spikes_valid;
  logic          spikes_ready;
  logic [AW-1:0] evt_addr;
  logic          evt_last;
  logic          evt_none;
  logic          evt_valid;
  logic          evt_ready;

  modport slave (
    input  spikes,
    input  spikes_valid,
    output spikes_ready,
    output evt_addr,
    output evt_last,
    output evt_none,
    output evt_valid,
    input  evt_ready
  );

  modport master (
    output spikes,
    output spikes_valid,
    input  spikes_ready,
    input  evt_addr,
    input  evt_last,
    input  evt_none,
    input  evt_valid,
    output evt_ready
  );
endinterface

// File: rtl/spike_event_encoder.sv
// Spike vector to address-event stream encoder, ascending index order.
// Optional event counter enabled by defining SPIKE_EVT_COUNT_EN.
module spike_event_encoder #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SPIKE_EVT_COUNT_EN
  input  logic        clr_count,
  output logic [15:0] evt_count,
`endif
  spike_event_encoder_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state;
  logic [N-1:0]  pend;
  logic [N-1:0]  nxt_pend;
  logic          hs;
  logic          acc;

  function automatic logic [AW-1:0] low_idx(
    input logic [N-1:0] m
  );
    logic [AW-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--)
      if (m[i]) r = AW'(i);
    return r;
  endfunction

  function automatic logic one_hot(
    input logic [N-1:0] m
  );
    return (m != '0) &&
           ((m & (m - N'(1))) == '0);
  endfunction

  assign hs = bus.evt_valid && bus.evt_ready;
  assign bus.spikes_ready =
    (state == IDLE) || (hs && bus.evt_last);
  assign acc = bus.spikes_valid && bus.spikes_ready;
  assign nxt_pend =
    pend & ~(N'(1) << bus.evt_addr);

  // pend still holds the bit of the beat on the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pend          <= '0;
      bus.evt_valid <= 1'b0;
      bus.evt_last  <= 1'b0;
      bus.evt_none  <= 1'b0;
      bus.evt_addr  <= '0;
    end else if (acc) begin
      state         <= EMIT;
      pend          <= bus.spikes;
      bus.evt_valid <= 1'b1;
      bus.evt_none  <= (bus.spikes == '0);
      bus.evt_last  <= (bus.spikes == '0) ||
                       one_hot(bus.spikes);
      bus.evt_addr  <= low_idx(bus.spikes);
    end else if (hs) begin
      pend <= nxt_pend;
      if (bus.evt_last) begin
        state         <= IDLE;
        bus.evt_valid <= 1'b0;
        bus.evt_last  <= 1'b0;
        bus.evt_none  <= 1'b0;
        bus.evt_addr  <= '0;
      end else begin
        bus.evt_addr <= low_idx(nxt_pend);
        bus.evt_last <= one_hot(nxt_pend);
      end
    end
  end

`ifdef SPIKE_EVT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      evt_count <= '0;
    else if (clr_count)
      evt_count <= '0;
    else if (hs && !bus.evt_none &&
             evt_count != 16'hFFFF)
      evt_count <= evt_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_spike_event_encoder.sv
// Scoreboard bench for spike_event_encoder.
// Builds with or without SPIKE_EVT_COUNT_EN.
module tb_spike_event_encoder;
  localparam int N  = 8;
  localparam int AW = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic          last;
    logic          none;
  } beat_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  beat_t q[$];

  bit rdy_rand  = 0;
  bit rdy_fixed = 1;
  bit clr_rand  = 0;

  spike_event_encoder_if #(.N(N), .AW(AW)) bus_if ();

`ifdef SPIKE_EVT_COUNT_EN
  logic        clr_count;
  logic [15:0] evt_count;
  int          m_count = 0;
`endif

  spike_event_encoder #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SPIKE_EVT_COUNT_EN
    .clr_count (clr_count),
    .evt_count (evt_count),
`endif
    .bus       (bus_if)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               nm, act, exp);
    end
  endtask

  // expected beats straight from the vector's set bits
  task automatic push_beats(input logic [N-1:0] v);
    int k = $countones(v);
    int j = 0;
    if (k == 0) begin
      q.push_back('{addr: '0, last: 1'b1, none: 1'b1});
    end else begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) begin
          j++;
          q.push_back('{addr: AW'(i),
                        last: (j == k),
                        none: 1'b0});
        end
      end
    end
  endtask

  task automatic chk_ready();
    bit exp;
    exp = (q.size() == 0) ||
          (q.size() == 1 && bus_if.evt_ready);
    check("spikes_ready",
          32'(bus_if.spikes_ready), 32'(exp));
  endtask

  task automatic drive_ctl();
    bus_if.evt_ready = rdy_rand ?
      ($urandom_range(0, 3) != 0) : rdy_fixed;
`ifdef SPIKE_EVT_COUNT_EN
    clr_count = clr_rand &&
      ($urandom_range(0, 31) == 0);
`endif
  endtask

  task automatic send(input logic [N-1:0] v);
    bit acc = 0;
    bus_if.spikes       = v;
    bus_if.spikes_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      chk_ready();
      acc = bus_if.spikes_ready;
      @(posedge clk);
      #1;
      if (acc) push_beats(v);
      drive_ctl();
    end
    if (!acc) check("accept_timeout", 32'(acc), 1);
    bus_if.spikes_valid = 1'b0;
    bus_if.spikes       = N'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_ready();
      @(posedge clk);
      #1;
      drive_ctl();
      bus_if.spikes = N'($urandom);
    end
  endtask

  // monitor: pops one expected beat per observed handshake
  initial begin
    bit    stalled = 0;
    beat_t held;
    beat_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        stalled = 0;
`ifdef SPIKE_EVT_COUNT_EN
        m_count = 0;
`endif
        continue;
      end
`ifdef SPIKE_EVT_COUNT_EN
      check("evt_count", 32'(evt_count),
            32'(m_count));
`endif
      check("evt_valid", 32'(bus_if.evt_valid),
            32'(q.size() != 0));
      if (bus_if.evt_valid) begin
        if (stalled) begin
          check("hold_addr", 32'(bus_if.evt_addr),
                32'(held.addr));
          check("hold_last", 32'(bus_if.evt_last),
                32'(held.last));
          check("hold_none", 32'(bus_if.evt_none),
                32'(held.none));
        end
        if (bus_if.evt_ready) begin
          stalled = 0;
          if (q.size() != 0) begin
            e = q.pop_front();
            check("evt_addr", 32'(bus_if.evt_addr),
                  32'(e.addr));
            check("evt_last", 32'(bus_if.evt_last),
                  32'(e.last));
            check("evt_none", 32'(bus_if.evt_none),
                  32'(e.none));
          end
        end else begin
          stalled = 1;
          held = '{addr: bus_if.evt_addr,
                   last: bus_if.evt_last,
                   none: bus_if.evt_none};
        end
      end else begin
        stalled = 0;
      end
`ifdef SPIKE_EVT_COUNT_EN
      if (clr_count)
        m_count = 0;
      else if (bus_if.evt_valid && bus_if.evt_ready &&
               !bus_if.evt_none && m_count < 65535)
        m_count++;
`endif
    end
  end

  initial begin
    logic [N-1:0] v;
    rst_n               = 1'b0;
    bus_if.spikes       = '0;
    bus_if.spikes_valid = 1'b0;
    bus_if.evt_ready    = 1'b0;
`ifdef SPIKE_EVT_COUNT_EN
    clr_count = 1'b0;
`endif
    #12;
    check("rst_valid", 32'(bus_if.evt_valid), 0);
    check("rst_last", 32'(bus_if.evt_last), 0);
    check("rst_none", 32'(bus_if.evt_none), 0);
    check("rst_addr", 32'(bus_if.evt_addr), 0);
`ifdef SPIKE_EVT_COUNT_EN
    check("rst_count", 32'(evt_count), 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_ready", 32'(bus_if.spikes_ready), 1);

    rdy_fixed = 1;
    drive_ctl();
    send(8'hA4);
    idle(5);
    send(8'h00);
    idle(3);

    rdy_fixed = 0;
    drive_ctl();
    send(8'h81);
    idle(3);
    rdy_fixed = 1;
    idle(4);

    send(8'h10);
    send(8'h03);
    idle(5);

    // reset while the second beat of 8'hFF is presented
    send(8'hFF);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus_if.evt_valid), 0);
    check("midrst_addr", 32'(bus_if.evt_addr), 0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    check("postrst_ready",
          32'(bus_if.spikes_ready), 1);
    idle(6);

    rdy_rand = 1;
    clr_rand = 1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = N'(1) << $urandom_range(0, N - 1);
        default: v = N'($urandom);
      endcase
      send(v);
      if ($urandom_range(0, 2) == 0)
        idle($urandom_range(1, 3));
    end
    rdy_rand = 0;
    clr_rand = 0;
    rdy_fixed = 1;
    idle(12);

`ifdef SPIKE_EVT_COUNT_EN
    for (int n = 0; n < 8200; n++) send(8'hFF);
    idle(10);
    check("count_sat", 32'(evt_count), 32'hFFFF);
    send(8'hFF);
    @(posedge clk);
    #1;
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
    check("count_clr", 32'(evt_count), 0);
    idle(12);
`endif

    check("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
